aes_round_key_buf: RTL and testbench
====================================

# aes_round_key_buf

Round-key buffer and streamer sitting directly downstream of the AES-128 key-expansion stage. It captures the cipher key plus the NR round keys the expansion stage emits, then holds all NR+1 keys. On request it streams them to the cipher datapath in forward order for encryption or reverse order for decryption. Expansion runs once per key; any number of cipher passes can then reuse the stored schedule.

## Interface
- NR, 10: number of rounds; NR+1 keys are stored.
- KW, 128: round-key width in bits.

- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a new schedule; key_i is captured as key 0.
- key_i  in  KW  cipher key, sampled only when start_i is high.
- rk_valid_i  in  1  round key from the expansion stage is valid this cycle.
- rk_i  in  KW  round key from the expansion stage.
- pass_i  in  1  request one streaming pass; honoured only in READY.
- dec_i  in  1  pass direction, sampled with pass_i: 0 forward (0..NR), 1 reverse (NR..0).
- out_valid_o  out  1  out_key_o and out_rnd_o hold a valid key.
- out_ready_i  in  1  consumer accepts the key this cycle.
- out_key_o  out  KW  streamed round key.
- out_rnd_o  out  4  index of the streamed key, 0..NR.
- full_o  out  1  all NR+1 keys are stored.
- busy_o  out  1  state is FILL or STREAM.
- ovf_o  out  1  sticky flag: rk_valid_i was asserted outside FILL.

## Operation
- States: IDLE, FILL, READY, STREAM.
- Reset: state is IDLE, fill count is 0, and out_valid_o, full_o, busy_o, ovf_o, out_rnd_o and out_key_o are all 0. Key storage is not reset.
- start_i in any state:
  - write key_i to slot 0 and set the fill count to 1;
  - clear full_o and ovf_o;
  - go to FILL.
  start_i aborts an active STREAM; out_valid_o drops in the next cycle.
- FILL:
  - each rk_valid_i writes rk_i to the slot given by the fill count, then increments the count;
  - after the write with count == NR, go to READY and set full_o.
- rk_valid_i while not in FILL: ignored and sets ovf_o. If start_i and rk_valid_i arrive together, start_i wins: rk_i is dropped and ovf_o is cleared.
- READY + pass_i: latch dec_i, load the index with 0 (forward) or NR (reverse), go to STREAM. pass_i in any other state is ignored.
- STREAM:
  - out_valid_o is held high, out_key_o shows the key at the current index, and out_rnd_o shows the index;
  - on each cycle with out_valid_o and out_ready_i, the index moves by +1 (forward) or −1 (reverse);
  - after the transfer of the last key (index NR forward, 0 reverse), go to READY with out_valid_o low in the next cycle.
- Stored keys are retained through passes. Only start_i or reset invalidates them.
- Index arithmetic is 4-bit unsigned and never wraps: the terminal index ends the pass before any wrap.
- While out_valid_o is high and out_ready_i is low, out_key_o and out_rnd_o are held stable.

## Timing
- All outputs are registered.
- full_o rises in the cycle after the NR-th rk_valid_i capture.
- out_valid_o rises in the cycle after pass_i is accepted in READY.
- Throughput is one key per cycle with out_ready_i held high, so a pass of NR+1 keys takes NR+1 cycles.
- The expansion stage may present rk_valid_i back-to-back or with gaps; there is no back-pressure toward it.
- Asynchronous reset mid-FILL or mid-STREAM: all outputs reach their reset values immediately, and the buffer must be refilled.

## Structure
- aes_pkg gains:
  - constant AES_NR = 10;
  - typedef rnd_idx_t (logic [3:0]);
  - enum kbuf_state_t {IDLE, FILL, READY, STREAM}.
  The existing aes_128 type is reused for key ports.
- One sub-module, aes_rk_regfile: NR+1 × KW storage with one write port and one combinational read port, non-reset. The FSM, counters and output registers stay in the top module.

## Test plan
- Reset, then start_i with key_i = 2b7e1516_28aed2a6_abf71588_09cf4f3c, then 10 FIPS-197 round keys with rk_valid_i -> full_o = 1 one cycle after the 10th key; busy_o falls.
- Forward pass with out_ready_i = 1 -> 11 consecutive beats with out_rnd_o 0..10; beat 10 is d014f9a8_c9ee2589_e13f0cc8_b6630ca6; then out_valid_o = 0.
- Reverse pass with out_ready_i toggling every other cycle -> out_rnd_o 10..0, keys held stable across stalls, 21 cycles total.
- rk_valid_i in READY -> ovf_o = 1 and contents unchanged (forward pass still matches); then start_i with rk_valid_i in the same cycle -> ovf_o = 0, slot 1 not written.
- start_i at beat 4 of a pass -> out_valid_o = 0 next cycle, state FILL, full_o = 0.
- nrst pulsed low mid-FILL (after 5 keys) -> all outputs 0 immediately; pass_i afterwards is ignored.

Source files
------------

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg : shared AES-128 types and constants for the key-schedule blocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;

    typedef logic [AES_KW-1:0] aes_128;
    typedef logic [3:0]        rnd_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } kbuf_state_t;

    // One streaming step; callers stop at the terminal index so this never wraps.
    function automatic rnd_idx_t step_idx(input rnd_idx_t idx, input logic dec);
        return dec ? rnd_idx_t'(idx - 4'd1) : rnd_idx_t'(idx + 4'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_key_buf_if.sv
// ----------------------------------------------------------------------------
// aes_round_key_buf_if : expansion-side, control and key-stream signals
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface aes_round_key_buf_if
    import aes_pkg::*;
#(
    parameter int KW = AES_KW
);

    logic           start_i;
    logic [KW-1:0]  key_i;
    logic           rk_valid_i;
    logic [KW-1:0]  rk_i;
    logic           pass_i;
    logic           dec_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [KW-1:0]  out_key_o;
    rnd_idx_t       out_rnd_o;
    logic           full_o;
    logic           busy_o;
    logic           ovf_o;

    modport master (
        output start_i, key_i, rk_valid_i, rk_i, pass_i, dec_i, out_ready_i,
        input  out_valid_o, out_key_o, out_rnd_o, full_o, busy_o, ovf_o
    );

    modport slave (
        input  start_i, key_i, rk_valid_i, rk_i, pass_i, dec_i, out_ready_i,
        output out_valid_o, out_key_o, out_rnd_o, full_o, busy_o, ovf_o
    );

endinterface

`default_nettype wire

// File: rtl/aes_rk_regfile.sv
// ----------------------------------------------------------------------------
// aes_rk_regfile : DEPTH x KW round-key store, one write / one async read port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_rk_regfile
    import aes_pkg::*;
#(
    parameter int DEPTH = AES_NR + 1,
    parameter int KW    = AES_KW
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  rnd_idx_t      i_wr_addr,
    input  logic [KW-1:0] i_wr_data,
    input  rnd_idx_t      i_rd_addr,
    output logic [KW-1:0] o_rd_data
);

    // Contents are deliberately not reset; the fill sequence defines them.
    logic [KW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = '0;
        if (int'(i_rd_addr) < DEPTH) begin
            o_rd_data = r_mem[i_rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_round_key_buf.sv
// ----------------------------------------------------------------------------
// aes_round_key_buf : captures an AES-128 key schedule, streams it fwd/reverse
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_round_key_buf
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic                clk,
    input  logic                nrst,
    aes_round_key_buf_if.slave  bus
);

    localparam rnd_idx_t c_LAST = rnd_idx_t'(NR);

    kbuf_state_t   r_state;
    kbuf_state_t   w_state_nxt;
    rnd_idx_t      r_fill_cnt;
    rnd_idx_t      w_fill_cnt_nxt;
    rnd_idx_t      r_idx;
    rnd_idx_t      w_idx_nxt;
    logic          r_dec;
    logic          w_dec_nxt;
    logic          r_full;
    logic          w_full_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic          r_out_valid;
    logic          r_busy;
    logic [KW-1:0] r_out_key;
    rnd_idx_t      r_out_rnd;

    logic          w_wr_en;
    rnd_idx_t      w_wr_addr;
    logic [KW-1:0] w_wr_data;
    logic [KW-1:0] w_rd_data;
    logic          w_last;

    // The read port looks ahead at the next index so the output key register
    // loads in the same edge the index moves.
    aes_rk_regfile #(
        .DEPTH (NR + 1),
        .KW    (KW)
    ) u_regfile (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_idx_nxt),
        .o_rd_data (w_rd_data)
    );

    assign w_last = r_dec ? (r_idx == '0) : (r_idx == c_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_idx_nxt      = r_idx;
        w_dec_nxt      = r_dec;
        w_full_nxt     = r_full;
        w_ovf_nxt      = r_ovf;
        w_wr_en        = 1'b0;
        w_wr_addr      = r_fill_cnt;
        w_wr_data      = bus.rk_i;

        if (bus.start_i) begin
            // A new schedule overrides everything, including a coincident rk.
            w_wr_en        = 1'b1;
            w_wr_addr      = '0;
            w_wr_data      = bus.key_i;
            w_fill_cnt_nxt = rnd_idx_t'(1);
            w_full_nxt     = 1'b0;
            w_ovf_nxt      = 1'b0;
            w_state_nxt    = FILL;
        end else begin
            if (bus.rk_valid_i && (r_state != FILL)) begin
                w_ovf_nxt = 1'b1;
            end

            case (r_state)
                FILL: begin
                    if (bus.rk_valid_i) begin
                        w_wr_en        = 1'b1;
                        w_fill_cnt_nxt = step_idx(r_fill_cnt, 1'b0);
                        if (r_fill_cnt == c_LAST) begin
                            w_full_nxt  = 1'b1;
                            w_state_nxt = READY;
                        end
                    end
                end
                READY: begin
                    if (bus.pass_i) begin
                        w_dec_nxt   = bus.dec_i;
                        w_idx_nxt   = bus.dec_i ? c_LAST : '0;
                        w_state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    if (bus.out_ready_i) begin
                        if (w_last) begin
                            w_state_nxt = READY;
                        end else begin
                            w_idx_nxt = step_idx(r_idx, r_dec);
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_fill_cnt  <= '0;
            r_idx       <= '0;
            r_dec       <= 1'b0;
            r_full      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_key   <= '0;
            r_out_rnd   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_dec       <= w_dec_nxt;
            r_full      <= w_full_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= (w_state_nxt == STREAM);
            r_busy      <= (w_state_nxt == FILL) || (w_state_nxt == STREAM);
            if (w_state_nxt == STREAM) begin
                r_out_key <= w_rd_data;
                r_out_rnd <= w_idx_nxt;
            end
        end
    end

    assign bus.out_valid_o = r_out_valid;
    assign bus.out_key_o   = r_out_key;
    assign bus.out_rnd_o   = r_out_rnd;
    assign bus.full_o      = r_full;
    assign bus.busy_o      = r_busy;
    assign bus.ovf_o       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_key_buf.sv
// ----------------------------------------------------------------------------
// tb_aes_round_key_buf : directed + randomized bench for aes_round_key_buf
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_aes_round_key_buf;
    import aes_pkg::*;

    localparam logic [127:0] C_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    logic clk;
    logic nrst;

    aes_round_key_buf_if #(.KW(128)) bus ();

    aes_round_key_buf #(
        .NR (10),
        .KW (128)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    int           n_vec;
    int           n_fail;
    logic [127:0] m_keys [11];
    int           m_fill;
    logic [127:0] fips [11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.out_valid_o, 0);
        check({tag, "_full"},  bus.full_o, 0);
        check({tag, "_busy"},  bus.busy_o, 0);
        check({tag, "_ovf"},   bus.ovf_o, 0);
        check({tag, "_rnd"},   bus.out_rnd_o, 0);
        check({tag, "_key"},   bus.out_key_o, 0);
    endtask

    task automatic do_start(input logic [127:0] k, input logic with_rk);
        bus.start_i    = 1'b1;
        bus.key_i      = k;
        bus.rk_valid_i = with_rk;
        bus.rk_i       = rand128();
        tick();
        bus.start_i    = 1'b0;
        bus.rk_valid_i = 1'b0;
        m_keys[0] = k;
        m_fill    = 1;
    endtask

    task automatic feed_rk(input logic [127:0] rk, input int gap);
        repeat (gap) tick();
        bus.rk_valid_i = 1'b1;
        bus.rk_i       = rk;
        tick();
        bus.rk_valid_i = 1'b0;
        if (m_fill <= 10) begin
            m_keys[m_fill] = rk;
            m_fill++;
        end
    endtask

    // mode 0: always ready, 1: ready on alternate cycles, 2: random ready
    task automatic run_pass(input logic dec, input int mode, input int exp_cycles, input logic chk10);
        int   q[$];
        int   cycles;
        logic rdy;
        for (int k = 0; k <= 10; k++) q.push_back(dec ? 10 - k : k);
        bus.dec_i  = dec;
        bus.pass_i = 1'b1;
        tick();
        bus.pass_i = 1'b0;
        bus.dec_i  = 1'b0;
        cycles = 0;
        while (q.size() > 0 && cycles < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.out_ready_i = rdy;
            check("pass_valid", bus.out_valid_o, 1);
            check("pass_busy",  bus.busy_o, 1);
            check("pass_rnd",   bus.out_rnd_o, q[0]);
            check("pass_key",   bus.out_key_o, m_keys[q[0]]);
            if (chk10 && q[0] == 10) check("beat10_key", bus.out_key_o, C_RK10);
            tick();
            cycles++;
            if (rdy) void'(q.pop_front());
        end
        bus.out_ready_i = 1'b0;
        check("pass_remaining", q.size(), 0);
        check("pass_end_valid", bus.out_valid_o, 0);
        check("pass_end_full",  bus.full_o, 1);
        if (exp_cycles > 0) check("pass_cycles", cycles, exp_cycles);
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        m_fill = 0;
        bus.start_i     = 1'b0;
        bus.key_i       = '0;
        bus.rk_valid_i  = 1'b0;
        bus.rk_i        = '0;
        bus.pass_i      = 1'b0;
        bus.dec_i       = 1'b0;
        bus.out_ready_i = 1'b0;

        fips[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        fips[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        fips[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        fips[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        fips[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        fips[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        fips[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        fips[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        fips[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        fips[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        fips[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        nrst = 1'b1;
        #2 nrst = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        nrst = 1'b1;
        tick();

        bus.pass_i = 1'b1;
        tick();
        bus.pass_i = 1'b0;
        check("idle_pass_valid", bus.out_valid_o, 0);

        // FIPS-197 schedule
        do_start(fips[0], 1'b0);
        check("start_busy", bus.busy_o, 1);
        check("start_full", bus.full_o, 0);
        for (int i = 1; i <= 10; i++) begin
            feed_rk(fips[i], 0);
            if (i < 10) begin
                check("fill_full_low", bus.full_o, 0);
            end else begin
                check("fill_full_high", bus.full_o, 1);
                check("fill_busy_low",  bus.busy_o, 0);
            end
        end

        run_pass(1'b0, 0, 11, 1'b1);
        run_pass(1'b1, 1, 21, 1'b0);

        // stray round key while READY
        bus.rk_valid_i = 1'b1;
        bus.rk_i       = rand128();
        tick();
        bus.rk_valid_i = 1'b0;
        check("ovf_set",  bus.ovf_o, 1);
        check("ovf_full", bus.full_o, 1);
        run_pass(1'b0, 0, 11, 1'b1);
        check("ovf_sticky", bus.ovf_o, 1);

        // start wins over a coincident rk; random schedule with gaps
        do_start(rand128(), 1'b1);
        check("start_rk_ovf",   bus.ovf_o, 0);
        check("start_rk_full",  bus.full_o, 0);
        check("start_rk_busy",  bus.busy_o, 1);
        check("start_rk_valid", bus.out_valid_o, 0);
        for (int i = 1; i <= 10; i++) feed_rk(rand128(), $urandom_range(0, 2));
        check("rand_fill_full", bus.full_o, 1);
        run_pass(1'($urandom_range(0, 1)), 2, 0, 1'b0);
        run_pass(1'b1, 2, 0, 1'b0);
        run_pass(1'b0, 2, 0, 1'b0);

        // abort at beat 4
        bus.dec_i  = 1'b0;
        bus.pass_i = 1'b1;
        tick();
        bus.pass_i      = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (4) tick();
        check("abort_rnd4", bus.out_rnd_o, 4);
        do_start(rand128(), 1'b0);
        bus.out_ready_i = 1'b0;
        check("abort_valid", bus.out_valid_o, 0);
        check("abort_busy",  bus.busy_o, 1);
        check("abort_full",  bus.full_o, 0);

        // async reset mid-fill
        for (int i = 0; i < 5; i++) feed_rk(rand128(), 0);
        check("midfill_busy", bus.busy_o, 1);
        #2 nrst = 1'b0;
        #1;
        check_reset_outputs("async");
        #2 nrst = 1'b1;
        tick();
        bus.pass_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_valid", bus.out_valid_o, 0);
            check("post_reset_busy",  bus.busy_o, 0);
        end
        bus.pass_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
